game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level scene sequencer for the game: TITLE -> ROAM -> fade -> BATTLE -> fade -> ROAM ... -> VICTORY/GAMEOVER.
//  Owns cur_battle (0-4) and is_roam for the roam scene, and gates its keycode.
//  Produces fade_level for the palette/colour mapper.
//  Sits between the keyboard/VGA timing and the roam and battle scene blocks.
// PARAMETERS
//  NUM_BATTLES      5      elite battles to win; cur_battle runs 0..NUM_BATTLES-1
//  FADE_MAX         4'd15  darkest fade_level
//  FRAMES_PER_STEP  2      frame ticks per fade_level step (>=1)
//  ENTER            8'h28  confirm keycode
// PORTS
//  Clk            in   1  system clock
//  Reset          in   1  synchronous, active-high
//  frame_clk      in   1  VGA vsync-rate clock, sampled on Clk
//  keycode        in   8  current keyboard keycode (8'h00 = none)
//  start_battle   in   1  roam scene request (combinational, level)
//  battle_done    in   1  one-Clk pulse from battle scene at battle end
//  battle_won     in   1  valid with battle_done; 1 = player won
//  roam_keycode   out  8  keycode forwarded to roam scene; 8'h00 when not in ROAM
//  is_title       out  1  title screen active
//  is_roam        out  1  roam scene active (ROAM, FADE_OUT, FADE_IN)
//  is_battle      out  1  battle scene active
//  is_victory     out  1  victory screen active
//  is_gameover    out  1  game-over screen active
//  cur_battle     out  3  index of current/next elite, 0..NUM_BATTLES-1
//  fade_level     out  4  0 = full brightness, FADE_MAX = black
// BEHAVIOUR
//  Reset:
//   - state=TITLE, cur_battle=0, fade_level=0, step_cnt=0.
//   - All is_* low except is_title; roam_keycode=0.
//   - Reset mid-fade or mid-battle returns to TITLE on the next Clk.
//  Frame tick:
//   - frame_clk registered once; tick = registered rising edge.
//   - tick is one Clk wide, asserted 2 Clk after the frame_clk rise.
//  ENTER edge:
//   - enter_edge = (keycode==ENTER) && (prev_keycode!=ENTER); prev_keycode registered.
//   - Holding ENTER produces exactly one edge.
//  States are one-hot-decoded into the is_* outputs (Moore). Outputs are registered from state.
//  TITLE:
//   - enter_edge -> ROAM with cur_battle=0, fade_level=0.
//  ROAM:
//   - roam_keycode=keycode.
//   - start_battle high -> FADE_OUT with fade_level=0, step_cnt=0.
//  FADE_OUT:
//   - roam_keycode=0.
//   - Each tick: step_cnt++. When step_cnt reaches FRAMES_PER_STEP-1 on a tick, step_cnt=0 and fade_level++.
//   - On the tick where fade_level would exceed FADE_MAX -> BATTLE, fade_level=0.
//  BATTLE:
//   - Exits only on battle_done.
//   - battle_done & won & cur_battle<NUM_BATTLES-1 -> FADE_IN, cur_battle++, fade_level=FADE_MAX.
//   - battle_done & won & cur_battle==NUM_BATTLES-1 -> VICTORY, cur_battle held.
//   - battle_done & !won -> GAMEOVER, cur_battle held.
//  FADE_IN:
//   - roam_keycode=0.
//   - Steps as FADE_OUT but fade_level decrements.
//   - On the step tick where fade_level==0 -> ROAM.
//  VICTORY / GAMEOVER:
//   - enter_edge -> TITLE, cur_battle=0, fade_level=0.
//  Boundary rules:
//   - start_battle is ignored outside ROAM. battle_done is ignored outside BATTLE.
//   - ENTER edges are ignored in ROAM, BATTLE and the fades.
//   - ENTER held across the VICTORY->TITLE transition must not skip TITLE (no new edge).
//   - tick and a state-exit event in the same Clk: the state exit wins; the fade counter restarts in the new state.
//   - cur_battle never wraps and never exceeds NUM_BATTLES-1.
//   - fade_level saturates at 0 and FADE_MAX.
// TESTING
//  1. Reset, then ENTER held 10 Clk -> one TITLE->ROAM transition; cur_battle=0; is_roam=1.
//  2. ROAM, start_battle=1, FPS=2 -> fade_level reaches 15 after 30 ticks.
//     Then BATTLE on the 32nd tick; roam_keycode=0 throughout.
//  3. BATTLE cur_battle=0, battle_done=1 won=1 -> FADE_IN with fade_level=15, cur_battle=1.
//     ROAM after fade_level reaches 0.
//  4. cur_battle=4, won=1 -> VICTORY; ENTER edge -> TITLE, cur_battle=0.
//     ENTER still held -> stays TITLE.
//  5. BATTLE, won=0 -> GAMEOVER; start_battle and battle_done pulses there -> no change.
//  6. Reset asserted in FADE_OUT at fade_level=7 -> next Clk TITLE, fade_level=0, cur_battle=0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Scene sequencer: TITLE -> ROAM -> fade -> BATTLE -> fade -> ROAM ... -> VICTORY/GAMEOVER.
// Owns the elite-battle index, the fade level for the palette mapper and the roam keycode gate.
module game_flow_ctrl #(
  parameter int          NUM_BATTLES     = 5,
  parameter logic [3:0]  FADE_MAX        = 4'd15,
  parameter int          FRAMES_PER_STEP = 2,
  parameter logic [7:0]  ENTER           = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       start_battle,
  input  logic       battle_done,
  input  logic       battle_won,
  output logic [7:0] roam_keycode,
  output logic       is_title,
  output logic       is_roam,
  output logic       is_battle,
  output logic       is_victory,
  output logic       is_gameover,
  output logic [2:0] cur_battle,
  output logic [3:0] fade_level
);

  localparam int               STEP_W      = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [2:0]       LAST_BATTLE = 3'(NUM_BATTLES - 1);

  typedef enum logic [2:0] {
    S_TITLE,
    S_ROAM,
    S_FADE_OUT,
    S_BATTLE,
    S_FADE_IN,
    S_VICTORY,
    S_GAMEOVER
  } state_t;

  state_t            state, state_d;
  logic [2:0]        cur_battle_d;
  logic [3:0]        fade_level_d;
  logic [STEP_W-1:0] step_cnt, step_cnt_d;

  logic       frame_q, frame_qq, tick;
  logic [7:0] prev_keycode;
  logic       enter_edge;

  assign enter_edge   = (keycode == ENTER) && (prev_keycode != ENTER);
  assign roam_keycode = (state == S_ROAM) ? keycode : 8'h00;

  // Input conditioning: frame_clk is synchronised once, and the edge pulse is itself a flop.
  // NOTE: every sequential block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q      <= 1'b0;
      frame_qq     <= 1'b0;
      tick         <= 1'b0;
      prev_keycode <= 8'h00;
    end else begin
      frame_q      <= frame_clk;
      frame_qq     <= frame_q;
      tick         <= frame_q & ~frame_qq;
      prev_keycode <= keycode;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_TITLE;
      cur_battle  <= 3'd0;
      fade_level  <= 4'd0;
      step_cnt    <= '0;
      is_title    <= 1'b1;
      is_roam     <= 1'b0;
      is_battle   <= 1'b0;
      is_victory  <= 1'b0;
      is_gameover <= 1'b0;
    end else begin
      state       <= state_d;
      cur_battle  <= cur_battle_d;
      fade_level  <= fade_level_d;
      step_cnt    <= step_cnt_d;
      is_title    <= (state_d == S_TITLE);
      is_roam     <= (state_d == S_ROAM) || (state_d == S_FADE_OUT) || (state_d == S_FADE_IN);
      is_battle   <= (state_d == S_BATTLE);
      is_victory  <= (state_d == S_VICTORY);
      is_gameover <= (state_d == S_GAMEOVER);
    end
  end

  // NOTE: every always_comb target is defaulted first so no path can hold a value and infer a latch.
  always_comb begin
    state_d      = state;
    cur_battle_d = cur_battle;
    fade_level_d = fade_level;
    step_cnt_d   = step_cnt;

    unique case (state)
      S_TITLE: begin
        if (enter_edge) begin
          state_d      = S_ROAM;
          cur_battle_d = 3'd0;
          fade_level_d = 4'd0;
          step_cnt_d   = '0;
        end
      end

      S_ROAM: begin
        if (start_battle) begin
          state_d      = S_FADE_OUT;
          fade_level_d = 4'd0;
          step_cnt_d   = '0;
        end
      end

      S_FADE_OUT: begin
        if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt_d = '0;
            if (fade_level == FADE_MAX) begin
              state_d      = S_BATTLE;
              fade_level_d = 4'd0;
            end else begin
              fade_level_d = fade_level + 4'd1;
            end
          end else begin
            step_cnt_d = step_cnt + 1'b1;
          end
        end
      end

      S_BATTLE: begin
        if (battle_done) begin
          if (!battle_won) begin
            state_d = S_GAMEOVER;
          end else if (cur_battle < LAST_BATTLE) begin
            state_d      = S_FADE_IN;
            cur_battle_d = cur_battle + 3'd1;
            fade_level_d = FADE_MAX;
            step_cnt_d   = '0;
          end else begin
            state_d = S_VICTORY;
          end
        end
      end

      S_FADE_IN: begin
        if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt_d = '0;
            if (fade_level == 4'd0) begin
              state_d = S_ROAM;
            end else begin
              fade_level_d = fade_level - 4'd1;
            end
          end else begin
            step_cnt_d = step_cnt + 1'b1;
          end
        end
      end

      S_VICTORY, S_GAMEOVER: begin
        if (enter_edge) begin
          state_d      = S_TITLE;
          cur_battle_d = 3'd0;
          fade_level_d = 4'd0;
          step_cnt_d   = '0;
        end
      end

      default: begin
        state_d      = S_TITLE;
        cur_battle_d = 3'd0;
        fade_level_d = 4'd0;
        step_cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a vector table walks the scene flow, with
// hand-written fade/reset sequences invoked from table entries.
module tb_game_flow_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       start_battle;
  logic       battle_done;
  logic       battle_won;
  logic [7:0] roam_keycode;
  logic       is_title, is_roam, is_battle, is_victory, is_gameover;
  logic [2:0] cur_battle;
  logic [3:0] fade_level;

  game_flow_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .start_battle (start_battle),
    .battle_done  (battle_done),
    .battle_won   (battle_won),
    .roam_keycode (roam_keycode),
    .is_title     (is_title),
    .is_roam      (is_roam),
    .is_battle    (is_battle),
    .is_victory   (is_victory),
    .is_gameover  (is_gameover),
    .cur_battle   (cur_battle),
    .fade_level   (fade_level)
  );

  always #5 Clk = ~Clk;

  // {title, roam, battle, victory, gameover}
  localparam logic [4:0] ST_T = 5'b10000;
  localparam logic [4:0] ST_R = 5'b01000;
  localparam logic [4:0] ST_B = 5'b00100;
  localparam logic [4:0] ST_V = 5'b00010;
  localparam logic [4:0] ST_G = 5'b00001;

  logic [4:0] st;
  assign st = {is_title, is_roam, is_battle, is_victory, is_gameover};

  typedef enum int {A_VEC, A_FADE_OUT, A_FADE_IN, A_RESET} act_t;

  typedef struct {
    string      name;
    act_t       act;
    logic [7:0] key;
    logic       sb;
    logic       bd;
    logic       bw;
    int         n;
    logic [4:0] est;
    logic [2:0] ecb;
    logic [3:0] efade;
    logic [7:0] erk;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [4:0] est, input logic [2:0] ecb,
                           input logic [3:0] efade, input logic [7:0] erk);
    check({name, ".state"}, 32'(st), 32'(est));
    check({name, ".cur_battle"}, 32'(cur_battle), 32'(ecb));
    check({name, ".fade"}, 32'(fade_level), 32'(efade));
    check({name, ".roam_key"}, 32'(roam_keycode), 32'(erk));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame_clk period; the resulting tick is consumed before the task returns.
  task automatic frame_tick();
    frame_clk = 1'b1;
    step();
    step();
    frame_clk = 1'b0;
    step();
    step();
  endtask

  task automatic add(input string name, input act_t act, input logic [7:0] key, input logic sb,
                     input logic bd, input logic bw, input int n, input logic [4:0] est,
                     input logic [2:0] ecb, input logic [3:0] efade, input logic [7:0] erk);
    vec_t v;
    v.name = name; v.act = act; v.key = key; v.sb = sb; v.bd = bd; v.bw = bw; v.n = n;
    v.est = est; v.ecb = ecb; v.efade = efade; v.erk = erk;
    vq.push_back(v);
  endtask

  // ROAM -> FADE_OUT -> BATTLE with FRAMES_PER_STEP=2: level k/2 after k ticks, BATTLE on tick 32.
  task automatic fade_out_seq(input string name, input logic [2:0] cb);
    keycode      = 8'h33;
    start_battle = 1'b1;
    step();
    start_battle = 1'b0;
    check_all({name, ".entry"}, ST_R, cb, 4'd0, 8'h00);
    for (int k = 1; k <= 32; k++) begin
      frame_tick();
      if (k < 32) check_all($sformatf("%s.t%0d", name, k), ST_R, cb, 4'(k / 2), 8'h00);
      else        check_all($sformatf("%s.t%0d", name, k), ST_B, cb, 4'd0, 8'h00);
    end
    keycode = 8'h00;
  endtask

  // FADE_IN from level 15 back to ROAM; the forwarded keycode reappears only in ROAM.
  task automatic fade_in_seq(input string name, input logic [2:0] cb);
    keycode = 8'h33;
    for (int k = 1; k <= 32; k++) begin
      frame_tick();
      if (k < 32) check_all($sformatf("%s.t%0d", name, k), ST_R, cb, 4'(15 - k / 2), 8'h00);
      else        check_all($sformatf("%s.t%0d", name, k), ST_R, cb, 4'd0, 8'h33);
    end
    keycode = 8'h00;
  endtask

  task automatic reset_seq(input string name, input logic [2:0] cb);
    keycode      = 8'h00;
    start_battle = 1'b1;
    step();
    start_battle = 1'b0;
    repeat (14) frame_tick();
    check_all({name, ".mid_fade"}, ST_R, cb, 4'd7, 8'h00);
    Reset = 1'b1;
    step();
    check_all({name, ".in_reset"}, ST_T, 3'd0, 4'd0, 8'h00);
    Reset = 1'b0;
    step();
    check_all({name, ".after"}, ST_T, 3'd0, 4'd0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // name               act         key    sb    bd    bw  n  state cb    fade   roam_key
    add("title_idle",     A_VEC,      8'h00, 1'b0, 1'b0, 1'b0, 2, ST_T, 3'd0, 4'd0,  8'h00);
    add("enter_to_roam",  A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 1, ST_R, 3'd0, 4'd0,  8'h28);
    add("enter_held",     A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 9, ST_R, 3'd0, 4'd0,  8'h28);
    add("roam_ign_done",  A_VEC,      8'h1A, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd0, 4'd0,  8'h1A);
    add("fo0",            A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd0, 4'd0,  8'h00);
    add("battle_ign_sb",  A_VEC,      8'h00, 1'b1, 1'b0, 1'b0, 2, ST_B, 3'd0, 4'd0,  8'h00);
    add("battle_ign_ent", A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 1, ST_B, 3'd0, 4'd0,  8'h00);
    add("win0",           A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd1, 4'd15, 8'h00);
    add("fadein_hold",    A_VEC,      8'h00, 1'b0, 1'b0, 1'b0, 2, ST_R, 3'd1, 4'd15, 8'h00);
    add("fi1",            A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd1, 4'd0,  8'h00);
    add("fo1",            A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd1, 4'd0,  8'h00);
    add("win1",           A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd2, 4'd15, 8'h00);
    add("fi2",            A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd2, 4'd0,  8'h00);
    add("fo2",            A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd2, 4'd0,  8'h00);
    add("lose2",          A_VEC,      8'h00, 1'b0, 1'b1, 1'b0, 1, ST_G, 3'd2, 4'd0,  8'h00);
    add("go_ign_sb",      A_VEC,      8'h00, 1'b1, 1'b0, 1'b0, 2, ST_G, 3'd2, 4'd0,  8'h00);
    add("go_ign_done",    A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_G, 3'd2, 4'd0,  8'h00);
    add("go_enter",       A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 1, ST_T, 3'd0, 4'd0,  8'h00);
    add("go_enter_held",  A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 3, ST_T, 3'd0, 4'd0,  8'h00);
    add("title_release",  A_VEC,      8'h00, 1'b0, 1'b0, 1'b0, 1, ST_T, 3'd0, 4'd0,  8'h00);
    add("restart",        A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 1, ST_R, 3'd0, 4'd0,  8'h28);
    add("r_fo0",          A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd0, 4'd0,  8'h00);
    add("r_win0",         A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd1, 4'd15, 8'h00);
    add("r_fi1",          A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd1, 4'd0,  8'h00);
    add("r_fo1",          A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd1, 4'd0,  8'h00);
    add("r_win1",         A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd2, 4'd15, 8'h00);
    add("r_fi2",          A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd2, 4'd0,  8'h00);
    add("r_fo2",          A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd2, 4'd0,  8'h00);
    add("r_win2",         A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd3, 4'd15, 8'h00);
    add("r_fi3",          A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd3, 4'd0,  8'h00);
    add("r_fo3",          A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd3, 4'd0,  8'h00);
    add("r_win3",         A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd4, 4'd15, 8'h00);
    add("r_fi4",          A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd4, 4'd0,  8'h00);
    add("r_fo4",          A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd4, 4'd0,  8'h00);
    add("victory",        A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_V, 3'd4, 4'd0,  8'h00);
    add("victory_hold",   A_VEC,      8'h00, 1'b1, 1'b0, 1'b0, 2, ST_V, 3'd4, 4'd0,  8'h00);
    add("vic_enter",      A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 1, ST_T, 3'd0, 4'd0,  8'h00);
    add("vic_enter_held", A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 4, ST_T, 3'd0, 4'd0,  8'h00);
    add("title_release2", A_VEC,      8'h00, 1'b0, 1'b0, 1'b0, 1, ST_T, 3'd0, 4'd0,  8'h00);
    add("restart2",       A_VEC,      8'h28, 1'b0, 1'b0, 1'b0, 1, ST_R, 3'd0, 4'd0,  8'h28);
    add("x_fo0",          A_FADE_OUT, 8'h00, 1'b0, 1'b0, 1'b0, 0, ST_B, 3'd0, 4'd0,  8'h00);
    add("x_win0",         A_VEC,      8'h00, 1'b0, 1'b1, 1'b1, 1, ST_R, 3'd1, 4'd15, 8'h00);
    add("x_fi1",          A_FADE_IN,  8'h00, 1'b0, 1'b0, 1'b0, 0, ST_R, 3'd1, 4'd0,  8'h00);
    add("reset_mid_fade", A_RESET,    8'h00, 1'b0, 1'b0, 1'b0, 0, ST_T, 3'd1, 4'd0,  8'h00);

    Reset        = 1'b1;
    frame_clk    = 1'b0;
    keycode      = 8'h00;
    start_battle = 1'b0;
    battle_done  = 1'b0;
    battle_won   = 1'b0;
    step();
    step();
    check_all("reset", ST_T, 3'd0, 4'd0, 8'h00);
    Reset = 1'b0;

    foreach (vq[i]) begin
      keycode      = vq[i].key;
      start_battle = vq[i].sb;
      battle_done  = vq[i].bd;
      battle_won   = vq[i].bw;
      case (vq[i].act)
        A_VEC: begin
          repeat (vq[i].n) step();
          check_all(vq[i].name, vq[i].est, vq[i].ecb, vq[i].efade, vq[i].erk);
        end
        A_FADE_OUT: fade_out_seq(vq[i].name, vq[i].ecb);
        A_FADE_IN:  fade_in_seq(vq[i].name, vq[i].ecb);
        A_RESET:    reset_seq(vq[i].name, vq[i].ecb);
        default:    ;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
